// File: rtl/instr_register_sched.sv
// instr_register_sched
//
// Write/read scheduler for the instruction register. Two producers share the
// single register write port through a round-robin arbiter; the register is
// sequenced as a circular queue (write_pointer / read_pointer) and drained by
// one consumer over a valid/ready handshake. A clear request zero-fills every
// entry over DEPTH cycles and then restores an empty queue.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   reqN_valid / reqN_ready       producer N handshake (ready == grant N
//                                 whenever reqN_valid is high)
//   reqN_opcode/_operand_a/_b     producer N write data
//   load_en, opcode, operand_a/b  register write strobe and data
//   write_pointer, read_pointer   register write / read addresses
//   instruction_word              register read data at read_pointer
//   rd_valid, rd_ready            consumer handshake
//   rd_instruction                word presented to the consumer
//   clear_req, clear_busy         start / in-progress of the clear sequence
//   clear_done                    one-cycle pulse after the last clear write
//   count, full, empty            queue occupancy

package instr_register_pkg;
  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;
  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;
endpackage

module instr_register_sched
  import instr_register_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  opcode_t      req0_opcode,
  input  operand_t     req0_operand_a,
  input  operand_t     req0_operand_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  opcode_t      req1_opcode,
  input  operand_t     req1_operand_a,
  input  operand_t     req1_operand_b,
  output logic         load_en,
  output opcode_t      opcode,
  output operand_t     operand_a,
  output operand_t     operand_b,
  output address_t     write_pointer,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output logic         rd_valid,
  input  logic         rd_ready,
  output instruction_t rd_instruction,
  input  logic         clear_req,
  output logic         clear_busy,
  output logic         clear_done,
  output logic [5:0]   count,
  output logic         full,
  output logic         empty
);

  localparam address_t   LAST_IDX  = address_t'(DEPTH - 1);
  localparam logic [5:0] FULL_CNT  = 6'(DEPTH);

  typedef enum logic {RUN, CLEAR} state_t;

  state_t     state_reg, state_next;
  address_t   wr_ptr_reg, wr_ptr_next;
  address_t   rd_ptr_reg, rd_ptr_next;
  address_t   clr_idx_reg, clr_idx_next;
  logic [5:0] count_reg, count_next;
  logic       last_grant_reg, last_grant_next;
  logic       clear_done_reg, clear_done_next;

  logic in_run;
  logic wr_eligible;
  logic lose0, lose1;
  logic grant0, grant1;
  logic wr_fire, rd_fire;

  assign in_run      = (state_reg == RUN);
  assign full        = (count_reg == FULL_CNT);
  assign empty       = (count_reg == 6'd0);
  assign count       = count_reg;
  assign clear_busy  = !in_run;
  assign clear_done  = clear_done_reg;
  assign wr_eligible = in_run && !full && !clear_req;

  // A requester only loses when the other one is also asking and it is the
  // other's turn. Ready is therefore high for an idle producer whenever a
  // write could be accepted, and equals the grant once it raises valid.
  assign lose0  = req1_valid && !last_grant_reg;
  assign lose1  = req0_valid &&  last_grant_reg;
  assign req0_ready = wr_eligible && !lose0;
  assign req1_ready = wr_eligible && !lose1;
  assign grant0 = req0_ready && req0_valid;
  assign grant1 = req1_ready && req1_valid;
  assign wr_fire = grant0 || grant1;

  assign rd_valid       = in_run && !empty;
  assign rd_fire        = rd_valid && rd_ready;
  assign read_pointer   = rd_ptr_reg;
  assign rd_instruction = instruction_word;

  // Register write port: zero-latency so the register captures on the same
  // edge that completes the producer handshake.
  always_comb begin
    load_en       = 1'b0;
    opcode        = ZERO;
    operand_a     = '0;
    operand_b     = '0;
    write_pointer = wr_ptr_reg;
    if (!in_run) begin
      load_en       = 1'b1;
      write_pointer = clr_idx_reg;
    end else if (grant1) begin
      load_en   = 1'b1;
      opcode    = req1_opcode;
      operand_a = req1_operand_a;
      operand_b = req1_operand_b;
    end else if (grant0) begin
      load_en   = 1'b1;
      opcode    = req0_opcode;
      operand_a = req0_operand_a;
      operand_b = req0_operand_b;
    end
    // Keep the register untouched while reset is held, even if a producer
    // is already presenting valid.
    if (!reset_n) begin
      load_en = 1'b0;
    end
  end

  always_comb begin
    state_next      = state_reg;
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    clr_idx_next    = clr_idx_reg;
    count_next      = count_reg;
    last_grant_next = last_grant_reg;
    clear_done_next = 1'b0;
    if (in_run) begin
      if (wr_fire) begin
        wr_ptr_next     = wr_ptr_reg + address_t'(1);
        last_grant_next = grant1;
      end
      // A read in the clear entry cycle still completes.
      if (rd_fire) begin
        rd_ptr_next = rd_ptr_reg + address_t'(1);
      end
      case ({wr_fire, rd_fire})
        2'b10:   count_next = count_reg + 6'd1;
        2'b01:   count_next = count_reg - 6'd1;
        default: count_next = count_reg;
      endcase
      if (clear_req) begin
        state_next = CLEAR;
      end
    end else begin
      clr_idx_next = clr_idx_reg + address_t'(1);
      if (clr_idx_reg == LAST_IDX) begin
        state_next      = RUN;
        wr_ptr_next     = '0;
        rd_ptr_next     = '0;
        count_next      = '0;
        clr_idx_next    = '0;
        clear_done_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= RUN;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      clr_idx_reg    <= '0;
      count_reg      <= '0;
      last_grant_reg <= 1'b1;
      clear_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      clr_idx_reg    <= clr_idx_next;
      count_reg      <= count_next;
      last_grant_reg <= last_grant_next;
      clear_done_reg <= clear_done_next;
    end
  end

endmodule

// File: tb/tb_instr_register_sched.sv
// Directed bench for instr_register_sched. Models the instruction register
// itself (captures on load_en, combinational read) and keeps a queue of the
// words expected by the consumer, in grant order.
module tb_instr_register_sched;
  import instr_register_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  opcode_t      req0_opcode, req1_opcode;
  operand_t     req0_operand_a, req0_operand_b, req1_operand_a, req1_operand_b;
  logic         load_en;
  opcode_t      opcode;
  operand_t     operand_a, operand_b;
  address_t     write_pointer, read_pointer;
  instruction_t instruction_word;
  logic         rd_valid, rd_ready;
  instruction_t rd_instruction;
  logic         clear_req, clear_busy, clear_done;
  logic [5:0]   count;
  logic         full, empty;

  int checks = 0;
  int errors = 0;

  instruction_t mem [32];
  instruction_t q[$];
  instruction_t w;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_en) mem[write_pointer] <= '{opcode, operand_a, operand_b};
  end
  assign instruction_word = mem[read_pointer];

  instr_register_sched #(.DEPTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_operand_a(req0_operand_a), .req0_operand_b(req0_operand_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_operand_a(req1_operand_a), .req1_operand_b(req1_operand_b),
    .load_en(load_en), .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .write_pointer(write_pointer), .read_pointer(read_pointer),
    .instruction_word(instruction_word),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_instruction(rd_instruction),
    .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
    .count(count), .full(full), .empty(empty)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic instruction_t mk(opcode_t o, int a, int b);
    instruction_t r;
    r.opc  = o;
    r.op_a = a;
    r.op_b = b;
    return r;
  endfunction

  initial begin : stim
    logic     lg;
    logic     g;
    address_t exp_wp, exp_rp;
    int       nwr;

    reset_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rd_ready = 0; clear_req = 0;
    req0_opcode = ZERO; req1_opcode = ZERO;
    req0_operand_a = 0; req0_operand_b = 0; req1_operand_a = 0; req1_operand_b = 0;

    // Reset values
    #2;
    chk("rst_load_en", load_en, 0);
    chk("rst_clear_busy", clear_busy, 0);
    chk("rst_clear_done", clear_done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_wp", write_pointer, 0);
    chk("rst_rp", read_pointer, 0);
    chk("rst_readies", {req1_ready, req0_ready}, 2'b11);
    #1 reset_n = 1'b1;

    // First write: req0 ADD 5,3
    req0_valid = 1; req0_opcode = ADD; req0_operand_a = 5; req0_operand_b = 3;
    #1;
    chk("w1_load_en", load_en, 1);
    chk("w1_wp", write_pointer, 0);
    chk("w1_ready0", req0_ready, 1);
    tick();
    req0_valid = 0;
    #1;
    chk("w1_rd_valid", rd_valid, 1);
    chk("w1_rp", read_pointer, 0);
    chk("w1_count", count, 1);
    chk("w1_data", rd_instruction, mk(ADD, 5, 3));

    // Round-robin fill from a fresh reset
    reset_n = 1'b0; #1; reset_n = 1'b1;
    q.delete();
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 32; i++) begin
      req0_opcode = ADD; req0_operand_a = 1000 + i; req0_operand_b = i;
      req1_opcode = SUB; req1_operand_a = 2000 + i; req1_operand_b = i;
      #1;
      chk("rr_grant", {req1_ready, req0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_wp", write_pointer, i[4:0]);
      if (i % 2 == 0) q.push_back(mk(ADD, 1000 + i, i));
      else            q.push_back(mk(SUB, 2000 + i, i));
      tick();
    end
    #1;
    chk("rr_full", full, 1);
    chk("rr_readies", {req1_ready, req0_ready}, 2'b00);
    chk("rr_count", count, 32);
    chk("rr_load_en", load_en, 0);
    req0_valid = 0; req1_valid = 0;

    // Drain in grant order
    rd_ready = 1;
    for (int i = 0; i < 32; i++) begin
      #1;
      w = q.pop_front();
      chk("drain_data", rd_instruction, w);
      tick();
    end
    rd_ready = 0;
    #1;
    chk("drain_empty", empty, 1);

    // count=5 then simultaneous write and read (pointers both at 0 now)
    req1_valid = 1;
    for (int i = 0; i < 6; i++) begin
      req1_opcode = PASSA; req1_operand_a = 50 + i; req1_operand_b = 60 + i;
      if (i == 5) rd_ready = 1;
      #1;
      chk("sim_wp", write_pointer, i[4:0]);
      if (i == 5) begin
        chk("sim_count_before", count, 5);
        chk("sim_oldest", rd_instruction, q[0]);
        w = q.pop_front();
      end
      q.push_back(mk(PASSA, 50 + i, 60 + i));
      tick();
    end
    req1_valid = 0; rd_ready = 0;
    #1;
    chk("sim_count", count, 5);
    chk("sim_rp", read_pointer, 1);
    chk("sim_wp_after", write_pointer, 6);

    // 40 writes interleaved with reads across the 31->0 wrap
    lg = 1'b1;            // last grant went to requester 1
    exp_wp = 5'd6; exp_rp = 5'd1; nwr = 0;
    for (int c = 0; c < 60; c++) begin
      req0_valid = (nwr < 40); req1_valid = (nwr < 40);
      req0_opcode = MULT; req0_operand_a = 3000 + c; req0_operand_b = c;
      req1_opcode = DIV;  req1_operand_a = 4000 + c; req1_operand_b = c;
      rd_ready = 1;
      #1;
      chk("wrap_rd_valid", rd_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("wrap_rp", read_pointer, exp_rp);
        chk("wrap_data", rd_instruction, q[0]);
        w = q.pop_front();
        exp_rp++;
      end
      if (nwr < 40) begin
        g = ~lg;
        chk("wrap_grant", {req1_ready, req0_ready}, g ? 2'b10 : 2'b01);
        chk("wrap_wp", write_pointer, exp_wp);
        if (g) q.push_back(mk(DIV, 4000 + c, c));
        else   q.push_back(mk(MULT, 3000 + c, c));
        exp_wp++;
        lg = g;
        nwr++;
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0; rd_ready = 0;
    #1;
    chk("wrap_empty", empty, 1);
    chk("wrap_final_wp", write_pointer, exp_wp);

    // Clear with count=7
    req0_valid = 1; req0_opcode = SUB; req0_operand_a = 9; req0_operand_b = 9;
    for (int i = 0; i < 7; i++) tick();
    req0_valid = 0;
    clear_req = 1; req1_valid = 1;
    #1;
    chk("clr_entry_count", count, 7);
    chk("clr_entry_load_en", load_en, 0);
    chk("clr_entry_ready1", req1_ready, 0);
    tick();
    for (int i = 0; i < 32; i++) begin
      if (i == 31) begin clear_req = 0; req1_valid = 0; end
      #1;
      chk("clr_load_en", load_en, 1);
      chk("clr_wp", write_pointer, i[4:0]);
      chk("clr_data", {opcode, operand_a, operand_b}, 68'd0);
      chk("clr_flags", {req1_ready, req0_ready, rd_valid, clear_busy}, 4'b0001);
      tick();
    end
    #1;
    chk("clr_done", clear_done, 1);
    chk("clr_busy_off", clear_busy, 0);
    chk("clr_count", count, 0);
    chk("clr_ptrs", {write_pointer, read_pointer}, 10'd0);
    tick();
    chk("clr_done_pulse", clear_done, 0);

    // Reset in the middle of a clear
    clear_req = 1;
    tick();
    clear_req = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_wp", write_pointer, 10);
    chk("mid_busy", clear_busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", clear_busy, 0);
    chk("mid_rst_load_en", load_en, 0);
    chk("mid_rst_count", count, 0);
    reset_n = 1'b1;
    req1_valid = 1; req1_opcode = MOD; req1_operand_a = 7; req1_operand_b = 8;
    #1;
    chk("post_load_en", load_en, 1);
    chk("post_wp", write_pointer, 0);
    chk("post_ready1", req1_ready, 1);
    tick();
    req1_valid = 0;
    #1;
    chk("post_data", rd_instruction, mk(MOD, 7, 8));
    chk("post_count", count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_register_sched.md
# instr_register_sched

Write/read scheduler for the instruction register. Arbitrates two instruction producers onto the single register write port (round-robin), sequences the register as a circular queue via `write_pointer`/`read_pointer`, and presents stored instruction words to one consumer through a valid/ready handshake. Also runs a multi-cycle clear sequence that zero-fills every entry. Sits between the stimulus sources and the instruction register's load/read ports.

## Interface
- `DEPTH`, 32: number of register entries; power of two, equal to 2^width(`address_t`).
- `clk`  in  1  clock; the same clock as the instruction register.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  producer 0/1 has an instruction to write.
- `req0_ready` / `req1_ready`  out  1  producer 0/1 write accepted this cycle.
- `req0_opcode`, `req1_opcode`  in  `opcode_t`  producer opcode.
- `req0_operand_a/b`, `req1_operand_a/b`  in  `operand_t`  producer operands.
- `load_en`  out  1  register write strobe.
- `opcode`, `operand_a`, `operand_b`  out  package types  write data to the register.
- `write_pointer`  out  `address_t`  register write address.
- `read_pointer`  out  `address_t`  register read address.
- `instruction_word`  in  `instruction_t`  register read data (combinational from `read_pointer`).
- `rd_valid`  out  1  `rd_instruction` holds an unread entry.
- `rd_ready`  in  1  consumer takes the entry.
- `rd_instruction`  out  `instruction_t`  equal to `instruction_word`.
- `clear_req`  in  1  start the clear sequence.
- `clear_busy`  out  1  clear sequence in progress.
- `clear_done`  out  1  one-cycle pulse when the clear sequence finishes.
- `count`  out  6  number of occupied entries (0..DEPTH).
- `full`, `empty`  out  1  `count==DEPTH` / `count==0`.

## Operation
- States: RUN, CLEAR. Reset forces RUN, wr_ptr=0, rd_ptr=0, count=0, last_grant=1, clr_idx=0.
- Reset output values: `load_en`=0, `clear_busy`=0, `clear_done`=0, `rd_valid`=0, `empty`=1, `full`=0, `count`=0, both pointers 0. Both readies are 1, because the block is empty in RUN.
- RUN, write side:
  - Writes are eligible when `!full && !clear_req`.
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester other than last_grant is granted, so requester 0 wins first after reset.
  - last_grant updates only on a grant.
  - `reqN_ready` equals grant N. Grant is combinational from the valids.
  - On a grant: `load_en`=1, `opcode`/`operand_a`/`operand_b` are muxed from the granted requester, and `write_pointer`=wr_ptr. The register captures on that same edge. wr_ptr increments mod DEPTH.
  - With no grant: `load_en`=0 and the data outputs are don't-care.
- RUN, read side:
  - `rd_valid` = `!empty`, `read_pointer` = rd_ptr, `rd_instruction` = `instruction_word`.
  - On `rd_valid && rd_ready`, rd_ptr increments mod DEPTH.
- Count: +1 on a write only, -1 on a read only, unchanged when both happen in the same cycle.
- Order: FIFO across both requesters, in grant order.
- CLEAR, entry:
  - Entered from RUN when `clear_req`=1. `clear_req` has priority over any write in the same cycle (no grant).
  - A read handshake in the entry cycle is still honored.
- CLEAR, operation:
  - Each cycle: `load_en`=1, `write_pointer`=clr_idx, `opcode`=ZERO, operands 0; clr_idx increments.
  - Readies=0, `rd_valid`=0, `clear_busy`=1.
  - `clear_req` is ignored while in CLEAR.
- CLEAR, exit: after the write at clr_idx=DEPTH-1:
  - next state RUN
  - wr_ptr=rd_ptr=count=0, clr_idx=0
  - `clear_done`=1 for exactly that first RUN cycle
  - last_grant unchanged

## Timing
- Write latency: zero. Data is in the register at the edge that ends the handshake cycle.
- Write-to-read visibility: an entry written at edge N has `rd_valid` asserted in the cycle after edge N.
- Same-cycle read and write are legal, including when rd_ptr==wr_ptr with count=0. In that case no read happens, because `rd_valid` is 0.
- Clear sequence: DEPTH cycles of `clear_busy`, then `clear_done` on the following cycle.
- Full: readies are 0. A read in that cycle re-opens writes from the next cycle.
- Wrap-around: pointers go from 31 to 0 with no gap cycle.
- Reset mid-operation, including mid-CLEAR: every state and output returns to its reset value immediately, with no wait for a clock edge.

## Test plan
- Reset, then `req0` ADD a=5 b=3: `load_en`=1 and `write_pointer`=0 in the same cycle; next cycle `rd_valid`=1, `read_pointer`=0, `count`=1, `rd_instruction` = {ADD,5,3}.
- Both requesters valid continuously, `rd_ready`=0: grants go 0,1,0,1,… and `write_pointer` runs 0..31; after 32 grants `full`=1, readies 0, `count`=32.
- `count`=5 with a simultaneous write and read: `count` stays 5, both pointers advance by 1, read data is the oldest entry.
- 40 writes interleaved with reads: pointers wrap 31→0, and the consumer sees all 40 words in grant order.
- `clear_req` with `count`=7: 32 cycles of `load_en`=1, `write_pointer` 0..31, opcode ZERO, operands 0, with readies and `rd_valid` held 0; then a `clear_done` pulse, with `count`=0 and both pointers 0.
- `reset_n` driven low while clr_idx=10: `clear_busy`=0, `load_en`=0, `count`=0 immediately; after release, a `req1` write lands at `write_pointer`=0.
